pc_branch_seq: RTL and testbench
================================

Name: pc_branch_seq

Overview:
- Program-counter sequencer sitting directly downstream of the condition flip-flop.
- Holds PC and performs sequential increment, conditional branch (brzr/brnz/brpl/brmi), jump-register (jr) and jump-and-link (jal).
- For branches it waits for the condition flip-flop's registered result, then redirects PC to PC + sign-extended C field or leaves it unchanged.
- Reports completion to the control unit with a done pulse.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CON_LAT, 2, clock cycles from br_req acceptance until con_in is valid; legal range 1..7.
- C_W, 19, width of the branch offset field inst[C_W-1:0], sign-extended to 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- inst  in  32  current instruction (IR contents); C field is inst[C_W-1:0].
- bus_in  in  32  bus value used as jr/jal target (Ra contents).
- con_in  in  1  registered branch condition from the condition flip-flop.
- pc_inc  in  1  PC <= PC + 1 (fetch increment).
- br_req  in  1  start a conditional branch.
- jr_req  in  1  PC <= bus_in.
- jal_req  in  1  link then jump: ra_out <= PC, PC <= bus_in.
- pc_out  out  32  current PC.
- ra_out  out  32  return address captured by jal.
- ra_we  out  1  one-cycle strobe: write ra_out into R15.
- busy  out  1  high while a branch is being resolved.
- br_taken  out  1  one-cycle strobe: branch resolved taken.
- br_done  out  1  one-cycle strobe: branch resolved (taken or not).

Behaviour:
- Reset (async, clr_n=0):
  - pc_out=RESET_PC; ra_out=0; ra_we, busy, br_taken, br_done = 0.
  - State IDLE; wait counter cleared.
  - Takes effect immediately, including mid-branch; the pending branch is discarded with no done pulse.
- States: IDLE, WAIT_CON, RESOLVE.
- IDLE, request priority when several are high in one cycle: jal_req > jr_req > br_req > pc_inc. Only the highest is executed; the others are dropped.
  - jal_req: next edge ra_out <= pc_out, pc_out <= bus_in, ra_we=1 for exactly that following cycle.
  - jr_req: next edge pc_out <= bus_in.
  - br_req:
    - Latch target = pc_out + sext(inst[C_W-1:0]) (mod 2^32, wrap-around allowed).
    - Load counter with CON_LAT-1, busy=1, go to WAIT_CON.
  - pc_inc: pc_out <= pc_out + 1; 32'hFFFF_FFFF wraps to 0.
- WAIT_CON:
  - Counter decrements each cycle; at 0 go to RESOLVE.
  - With CON_LAT=1, go straight to RESOLVE on the cycle after acceptance.
- RESOLVE:
  - Sample con_in once.
  - If 1: pc_out <= latched target, br_taken=1.
  - br_done=1 in either case; busy=0; return to IDLE.
  - Result visible on pc_out the cycle after RESOLVE.
- While busy=1, all requests are ignored (pc_inc, jr, jal, br). The control unit must hold off.
- The target is latched at acceptance, so inst changes during WAIT_CON do not affect the branch.
- Strobes (ra_we, br_taken, br_done) are registered and high for exactly one cycle.
- Total branch latency: br_req edge to br_done high = CON_LAT+1 cycles.

Optional Feature:
- Macro PC_BR_STATS_EN.
- Defined:
  - Adds outputs br_cnt[15:0] and taken_cnt[15:0], both reset to 0.
  - br_cnt increments on each br_done; taken_cnt increments on each br_taken.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include:
  - State encodings (IDLE=2'd0, WAIT_CON=2'd1, RESOLVE=2'd2).
  - Branch-opcode constants.
  - sext helper constant C_W.
- One natural sub-module: pc_target_adder (combinational 32-bit PC + sign-extended offset). Everything else stays inline.

Test Plan:
- Reset/inc: clr_n low then high, 3 pc_inc pulses -> pc_out 0,1,2,3. Assert clr_n mid-sequence -> pc_out=0 immediately.
- Branch taken: pc_out=0x10, inst[18:0]=19'h00005, br_req, con_in=1 at RESOLVE (CON_LAT=2) -> br_done and br_taken at cycle 3; pc_out=0x15.
- Branch not taken, negative offset: pc_out=0x10, inst[18:0]=19'h7FFFC (-4), con_in=0 -> br_done=1, br_taken=0, pc_out stays 0x10. Repeat with con_in=1 -> pc_out=0x0C.
- jal priority: pc_out=0x20, bus_in=0x80, jal_req+br_req+pc_inc same cycle -> pc_out=0x80, ra_out=0x20, ra_we one cycle, no busy.
- Busy lockout / reset mid-op: br_req, then pc_inc and jr_req during WAIT_CON -> ignored. Second run: clr_n low during WAIT_CON -> pc_out=RESET_PC, busy=0, no br_done.
- Wrap and stats (PC_BR_STATS_EN): pc_out=0xFFFF_FFFF, pc_inc -> pc_out=0. Two taken and one not-taken branch -> br_cnt=3, taken_cnt=2.

Source files
------------

// File: rtl/pc_branch_seq_pkg.sv
// rtl/pc_branch_seq_pkg.sv - shared types and constants for the PC branch sequencer
//    State encoding, branch-condition opcodes and default field widths used by
//    pc_branch_seq and pc_target_adder.
package pc_branch_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_CON = 2'd1,
      ST_RESOLVE  = 2'd2
   } state_e;

   // Branch opcodes and the condition codes carried in the instruction.
   localparam logic [4:0] OP_BR     = 5'd8;
   localparam logic [4:0] OP_BRL    = 5'd9;
   localparam logic [2:0] COND_BRZR = 3'd2;
   localparam logic [2:0] COND_BRNZ = 3'd3;
   localparam logic [2:0] COND_BRPL = 3'd4;
   localparam logic [2:0] COND_BRMI = 3'd5;

   // Default width of the C (offset) field and of the condition wait counter.
   localparam int C_W_DEFAULT = 19;
   localparam int CNT_W       = 3;

endpackage

// File: rtl/pc_target_adder.sv
// rtl/pc_target_adder.sv - combinational PC + sign-extended branch offset
//    pc_in  : current PC
//    off_in : C field, C_W bits, two's complement
//    tgt_out: pc_in + sext(off_in), modulo 2^32
module pc_target_adder
   import pc_branch_seq_pkg::*;
#(
   parameter int C_W = C_W_DEFAULT
) (
   input  logic [31:0]    pc_in,
   input  logic [C_W-1:0] off_in,
   output logic [31:0]    tgt_out
);

   logic [31:0] off_sext;

   assign off_sext = {{(32-C_W){off_in[C_W-1]}}, off_in};
   assign tgt_out  = pc_in + off_sext;

endmodule

// File: rtl/pc_branch_seq.sv
// rtl/pc_branch_seq.sv - program-counter sequencer: increment, branch, jr, jal
//    Inputs : clk, clr_n (async active-low), inst (C field in low C_W bits),
//             bus_in (jr/jal target), con_in (registered condition),
//             pc_inc / br_req / jr_req / jal_req requests.
//    Outputs: pc_out, ra_out, ra_we strobe, busy, br_taken / br_done strobes.
//    Macro PC_BR_STATS_EN adds saturating br_cnt and taken_cnt outputs.
module pc_branch_seq
   import pc_branch_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CON_LAT  = 2,
   parameter int          C_W      = C_W_DEFAULT
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [31:0] inst,
   input  logic [31:0] bus_in,
   input  logic        con_in,
   input  logic        pc_inc,
   input  logic        br_req,
   input  logic        jr_req,
   input  logic        jal_req,
   output logic [31:0] pc_out,
   output logic [31:0] ra_out,
   output logic        ra_we,
   output logic        busy,
   output logic        br_taken,
   output logic        br_done
`ifdef PC_BR_STATS_EN
   ,
   output logic [15:0] br_cnt,
   output logic [15:0] taken_cnt
`endif
);

   // Counter preload so that RESOLVE is reached CON_LAT edges after acceptance.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CON_LAT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ra_q, ra_d;
   logic [31:0]       tgt_q, tgt_d;
   logic              ra_we_q, ra_we_d;
   logic              taken_q, taken_d;
   logic              done_q, done_d;
   logic [31:0]       tgt_calc;

   // Opcode and register fields above the C field are decoded elsewhere.
   logic unused_inst_hi;
   assign unused_inst_hi = ^inst[31:C_W];

   pc_target_adder #(.C_W(C_W)) u_tgt (
      .pc_in   (pc_q),
      .off_in  (inst[C_W-1:0]),
      .tgt_out (tgt_calc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      ra_d    = ra_q;
      tgt_d   = tgt_q;
      ra_we_d = 1'b0;
      taken_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Fixed priority; lower-priority requests in the same cycle are dropped.
            if (jal_req) begin
               ra_d    = pc_q;
               pc_d    = bus_in;
               ra_we_d = 1'b1;
            end else if (jr_req) begin
               pc_d = bus_in;
            end else if (br_req) begin
               // Target captured now so later IR changes cannot disturb it.
               tgt_d   = tgt_calc;
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT_CON;
            end else if (pc_inc) begin
               pc_d = pc_q + 32'd1;
            end
         end
         ST_WAIT_CON: begin
            if (cnt_q == '0) begin
               state_d = ST_RESOLVE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESOLVE: begin
            if (con_in) begin
               pc_d    = tgt_q;
               taken_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pc_q    <= RESET_PC;
         ra_q    <= '0;
         tgt_q   <= '0;
         ra_we_q <= 1'b0;
         taken_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         ra_q    <= ra_d;
         tgt_q   <= tgt_d;
         ra_we_q <= ra_we_d;
         taken_q <= taken_d;
         done_q  <= done_d;
      end
   end

   assign pc_out   = pc_q;
   assign ra_out   = ra_q;
   assign ra_we    = ra_we_q;
   assign busy     = (state_q != ST_IDLE);
   assign br_taken = taken_q;
   assign br_done  = done_q;

`ifdef PC_BR_STATS_EN
   logic [15:0] br_cnt_q, br_cnt_d;
   logic [15:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (done_q && (br_cnt_q != 16'hFFFF)) br_cnt_d = br_cnt_q + 16'd1;
      if (taken_q && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else begin
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_seq.sv
// tb/tb_pc_branch_seq.sv - self-checking bench for pc_branch_seq
module tb_pc_branch_seq;

   localparam int          CON_LAT  = 2;
   localparam int          C_W      = 19;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic [31:0] inst = '0;
   logic [31:0] bus_in = '0;
   logic        con_in = 1'b0;
   logic        pc_inc = 1'b0;
   logic        br_req = 1'b0;
   logic        jr_req = 1'b0;
   logic        jal_req = 1'b0;
   logic [31:0] pc_out, ra_out;
   logic        ra_we, busy, br_taken, br_done;
`ifdef PC_BR_STATS_EN
   logic [15:0] br_cnt, taken_cnt;
`endif

   always #5 clk = ~clk;

   pc_branch_seq #(.RESET_PC(RESET_PC), .CON_LAT(CON_LAT), .C_W(C_W)) dut (
      .clk(clk), .clr_n(clr_n), .inst(inst), .bus_in(bus_in), .con_in(con_in),
      .pc_inc(pc_inc), .br_req(br_req), .jr_req(jr_req), .jal_req(jal_req),
      .pc_out(pc_out), .ra_out(ra_out), .ra_we(ra_we), .busy(busy),
      .br_taken(br_taken), .br_done(br_done)
`ifdef PC_BR_STATS_EN
      , .br_cnt(br_cnt), .taken_cnt(taken_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction-level reference: a branch is "cycles left until it reports done".
   logic [31:0] m_pc, m_ra, m_tgt;
   int          m_left;
   logic        m_ra_we, m_taken, m_done;
   int          m_br, m_tk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] sext_c(input logic [31:0] i);
      logic [31:0] v;
      v = i % (32'd1 << C_W);
      if (v >= (32'd1 << (C_W - 1))) v = v - (32'd1 << C_W);
      return v;
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC; m_ra = '0; m_tgt = '0; m_left = 0;
      m_ra_we = 0; m_taken = 0; m_done = 0; m_br = 0; m_tk = 0;
   endtask

   task automatic model_clock();
      if (m_done && m_br != 16'hFFFF) m_br++;
      if (m_taken && m_tk != 16'hFFFF) m_tk++;
      m_ra_we = 0; m_taken = 0; m_done = 0;
      if (m_left == 0) begin
         if (jal_req) begin
            m_ra = m_pc; m_pc = bus_in; m_ra_we = 1;
         end else if (jr_req) begin
            m_pc = bus_in;
         end else if (br_req) begin
            m_tgt  = m_pc + sext_c(inst);
            m_left = CON_LAT + 1;
         end else if (pc_inc) begin
            m_pc = m_pc + 1;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1;
            if (con_in) begin
               m_taken = 1;
               m_pc = m_tgt;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},    pc_out,   m_pc);
      chk({tag, ".ra"},    ra_out,   m_ra);
      chk({tag, ".ra_we"}, {31'd0, ra_we},    {31'd0, m_ra_we});
      chk({tag, ".busy"},  {31'd0, busy},     {31'd0, m_left != 0});
      chk({tag, ".taken"}, {31'd0, br_taken}, {31'd0, m_taken});
      chk({tag, ".done"},  {31'd0, br_done},  {31'd0, m_done});
`ifdef PC_BR_STATS_EN
      chk({tag, ".br_cnt"},    {16'd0, br_cnt},    m_br);
      chk({tag, ".taken_cnt"}, {16'd0, taken_cnt}, m_tk);
`endif
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic req(input logic jal, input logic jr, input logic br, input logic inc);
      jal_req = jal; jr_req = jr; br_req = br; pc_inc = inc;
   endtask

   task automatic load_pc(input logic [31:0] v);
      bus_in = v; req(0, 1, 0, 0);
      cyc("load");
      req(0, 0, 0, 0);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 clr_n = 1'b0;
      #1 model_reset();
      chk({tag, ".pc"},   pc_out, RESET_PC);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
      check_all(tag);
      #1 clr_n = 1'b1;
   endtask

   task automatic branch(input logic [31:0] off, input logic c, input string tag);
      inst = off; con_in = c; req(0, 0, 1, 0);
      cyc({tag, ".acc"});
      req(0, 0, 0, 0);
      inst = $urandom;
      for (int i = 0; i < CON_LAT; i++) cyc({tag, ".wait"});
      cyc({tag, ".res"});
      chk({tag, ".done_at_lat"}, {31'd0, br_done}, 32'd1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      clr_n = 1'b1;

      for (int i = 1; i <= 3; i++) begin
         req(0, 0, 0, 1);
         cyc("inc");
         chk("inc.value", pc_out, 32'(i));
      end
      req(0, 0, 0, 0);
      async_reset("rst_mid_inc");

      load_pc(32'h10);
      branch(32'h0000_0005, 1'b1, "br_taken");
      chk("br_taken.pc", pc_out, 32'h15);

      load_pc(32'h10);
      branch(32'h0007_FFFC, 1'b0, "br_neg_nt");
      chk("br_neg_nt.pc", pc_out, 32'h10);
      branch(32'h0007_FFFC, 1'b1, "br_neg_t");
      chk("br_neg_t.pc", pc_out, 32'h0C);

      load_pc(32'h20);
      bus_in = 32'h80; req(1, 1, 1, 1);
      cyc("jal_prio");
      chk("jal_prio.pc", pc_out, 32'h80);
      chk("jal_prio.ra", ra_out, 32'h20);
      req(0, 0, 0, 0);
      cyc("jal_after");

      inst = 32'h3; req(0, 0, 1, 0);
      cyc("lock.acc");
      bus_in = 32'hDEAD_0000; req(1, 1, 1, 1);
      for (int i = 0; i < CON_LAT + 1; i++) cyc("lock.wait");
      req(0, 0, 0, 0);
      cyc("lock.idle");

      inst = 32'h7; con_in = 1'b1; req(0, 0, 1, 0);
      cyc("rstwc.acc");
      req(0, 0, 0, 0);
      async_reset("rst_wait");
      repeat (CON_LAT + 2) cyc("rstwc.after");

      load_pc(32'hFFFF_FFFF);
      req(0, 0, 0, 1);
      cyc("wrap");
      chk("wrap.pc", pc_out, 32'h0);
      req(0, 0, 0, 0);

      model_reset();
      clr_n = 1'b0;
      #1 clr_n = 1'b1;
      branch(32'h1, 1'b1, "st1");
      branch(32'h2, 1'b0, "st2");
      branch(32'h3, 1'b1, "st3");
      cyc("st.idle");
`ifdef PC_BR_STATS_EN
      chk("stats.br_cnt", {16'd0, br_cnt}, 32'd3);
      chk("stats.taken_cnt", {16'd0, taken_cnt}, 32'd2);
`endif

      for (int i = 0; i < 3000; i++) begin
         jal_req = ($urandom_range(0, 9) == 0);
         jr_req  = ($urandom_range(0, 7) == 0);
         br_req  = ($urandom_range(0, 3) == 0);
         pc_inc  = ($urandom_range(0, 1) == 0);
         bus_in  = $urandom;
         inst    = $urandom;
         con_in  = $urandom_range(0, 1);
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
